// File: rtl/rto_core_param.sv
// Real-time output core: timestamped entries wait in an inferred-RAM FIFO and are
// released when the head timestamp meets the global counter. Option: RTO_CORE_STICKY_ERR_EN.
module rto_core_param #(
  parameter  int TS_W      = 64,
  parameter  int DATA_W    = 64,
  parameter  int DEPTH     = 8192,
  parameter  int PROG_FULL = 8100,
  parameter  int LATE_MODE = 0,
  parameter  int CNT_W     = 16,
  localparam int E_W       = TS_W + DATA_W,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             auto_start,
  input  logic             write,
  input  logic [E_W-1:0]   fifo_din,
  input  logic [TS_W-1:0]  counter,
  input  logic             err_clear,
  output logic [E_W-1:0]   rto_out,
  output logic             counter_matched,
  output logic             timestamp_error,
  output logic [E_W-1:0]   timestamp_error_data,
  output logic             overflow_error,
  output logic [E_W-1:0]   overflow_error_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] late_count
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [E_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [E_W-1:0]    rto_q, tsErrData_q, ovfData_q;
  logic              matched_q, tsErr_q, ovfErr_q;
  logic [CNT_W-1:0]  lateCount_q;

  logic [E_W-1:0]    head;
  logic [TS_W-1:0]   headTs;
  logic              active, match, late, pop, wrEn, ovf, release_;

  assign full   = level_q >= LVL_W'(PROG_FULL);
  assign empty  = level_q == '0;
  assign head   = mem[rdPtr_q];
  assign headTs = head[E_W-1:DATA_W];

  // A flush cycle suppresses every pop, write and the errors they would raise.
  assign active   = !empty && auto_start && !flush;
  assign match    = active && (headTs == counter);
  assign late     = active && (counter > headTs);
  assign pop      = match || late;
  assign wrEn     = write && !full && !flush;
  assign ovf      = write && full && !flush;
  assign release_ = match || (late && (LATE_MODE == 1));

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q] <= fifo_din;
  end

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    level_d = level_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      level_d = '0;
    end else begin
      if (pop)  rdPtr_d = rdPtr_q + ADDR_W'(1);
      if (wrEn) wrPtr_d = wrPtr_q + ADDR_W'(1);
      if (wrEn && !pop)      level_d = level_q + LVL_W'(1);
      else if (!wrEn && pop) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      level_q     <= '0;
      rto_q       <= '0;
      matched_q   <= 1'b0;
      tsErr_q     <= 1'b0;
      tsErrData_q <= '0;
      ovfErr_q    <= 1'b0;
      ovfData_q   <= '0;
      lateCount_q <= '0;
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      level_q   <= level_d;
      matched_q <= release_;
      if (release_) rto_q <= head;

      // A late event in the same cycle as err_clear counts as the first after the clear.
      if (late) begin
        if (err_clear)              lateCount_q <= CNT_W'(1);
        else if (lateCount_q != '1) lateCount_q <= lateCount_q + CNT_W'(1);
      end else if (err_clear) begin
        lateCount_q <= '0;
      end

`ifdef RTO_CORE_STICKY_ERR_EN
      if (late)           tsErr_q <= 1'b1;
      else if (err_clear) tsErr_q <= 1'b0;
      if (late && (!tsErr_q || err_clear)) tsErrData_q <= head;

      if (ovf)            ovfErr_q <= 1'b1;
      else if (err_clear) ovfErr_q <= 1'b0;
      if (ovf && (!ovfErr_q || err_clear)) ovfData_q <= fifo_din;
`else
      tsErr_q  <= late;
      ovfErr_q <= ovf;
      if (late) tsErrData_q <= head;
      if (ovf)  ovfData_q   <= fifo_din;
`endif
    end
  end

  assign rto_out              = rto_q;
  assign counter_matched      = matched_q;
  assign timestamp_error      = tsErr_q;
  assign timestamp_error_data = tsErrData_q;
  assign overflow_error       = ovfErr_q;
  assign overflow_error_data  = ovfData_q;
  assign level                = level_q;
  assign late_count           = lateCount_q;

endmodule
